// File: rtl/pipe_pkg.sv
// Shared widths, instruction layout and FSM encoding for the pipe_fetch issue stage.
package pipe_pkg;

  localparam int unsigned n   = 16;
  localparam int unsigned m   = 3;
  localparam int unsigned adr = 8;
  localparam int unsigned fun = 3;
  localparam int unsigned iw  = 21;

  localparam int unsigned CNT_W  = n;
  localparam int unsigned IMEM_D = 2 ** adr;

  localparam int unsigned HALT_POS = 20;
  localparam int unsigned F_LSB    = 17;
  localparam int unsigned RD_LSB   = 14;
  localparam int unsigned RS1_LSB  = 11;
  localparam int unsigned RS2_LSB  = 8;
  localparam int unsigned ADDR_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [fun-1:0] f;
    logic [m-1:0]   rd;
    logic [m-1:0]   rs1;
    logic [m-1:0]   rs2;
    logic [adr-1:0] addr;
  } iss_t;

  typedef struct packed {
    logic halt;
    iss_t body;
  } ins_t;

  typedef struct packed {
    logic         vld;
    logic [m-1:0] rd;
  } slot_t;

  // Splits a raw instruction word into its fields by bit position.
  function automatic ins_t decode(input logic [iw-1:0] w);
    ins_t d;
    d.halt      = w[HALT_POS];
    d.body.f    = w[F_LSB +: fun];
    d.body.rd   = w[RD_LSB +: m];
    d.body.rs1  = w[RS1_LSB +: m];
    d.body.rs2  = w[RS2_LSB +: m];
    d.body.addr = w[ADDR_LSB +: adr];
    return d;
  endfunction

endpackage

// File: rtl/pipe_fetch_if.sv
// Control, instruction-load and issue signals of the pipe_fetch stage.
interface pipe_fetch_if;
  import pipe_pkg::*;

  logic             start;
  logic [adr-1:0]   start_pc;
  logic             hold;
  logic             imem_we;
  logic [adr-1:0]   imem_waddr;
  logic [iw-1:0]    imem_wdata;

  logic             vld;
  logic [m-1:0]     rs1;
  logic [m-1:0]     rs2;
  logic [m-1:0]     rd;
  logic [fun-1:0]   f;
  logic [adr-1:0]   addr;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] icount;

  modport master (
    output start, start_pc, hold, imem_we, imem_waddr, imem_wdata,
    input  vld, rs1, rs2, rd, f, addr, busy, done, icount
  );

  modport slave (
    input  start, start_pc, hold, imem_we, imem_waddr, imem_wdata,
    output vld, rs1, rs2, rd, f, addr, busy, done, icount
  );

endinterface

// File: rtl/pipe_hazard.sv
// Read-after-write check of the fetched sources against the last two issue slots.
module pipe_hazard
  import pipe_pkg::*;
(
  input  logic [m-1:0] i_rs1,
  input  logic [m-1:0] i_rs2,
  input  slot_t        i_cur,
  input  slot_t        i_hist,
  output logic         o_stall
);

  logic w_hit_cur;
  logic w_hit_hist;

  assign w_hit_cur  = i_cur.vld  && ((i_rs1 == i_cur.rd)  || (i_rs2 == i_cur.rd));
  assign w_hit_hist = i_hist.vld && ((i_rs1 == i_hist.rd) || (i_rs2 == i_hist.rd));
  assign o_stall    = w_hit_cur | w_hit_hist;

endmodule

// File: rtl/pipe_fetch.sv
// Instruction fetch/issue stage: loadable imem, pc, RAW bubble insertion and halt.
module pipe_fetch
  import pipe_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  pipe_fetch_if.slave  bus
);

  logic [iw-1:0]    r_imem [IMEM_D];

  state_t           r_state;
  state_t           w_state_nxt;
  logic [adr-1:0]   r_pc;
  logic [adr-1:0]   w_pc_nxt;
  logic             r_vld;
  logic             w_vld_nxt;
  iss_t             r_iss;
  iss_t             w_iss_nxt;
  slot_t            r_hist;
  slot_t            w_hist_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_busy;
  logic [CNT_W-1:0] r_icount;
  logic [CNT_W-1:0] w_icount_nxt;

  ins_t             w_ins;
  slot_t            w_cur;
  logic             w_stall;

  assign w_ins = decode(r_imem[r_pc]);
  assign w_cur = '{vld: r_vld, rd: r_iss.rd};

  pipe_hazard u_hazard (
    .i_rs1   (w_ins.body.rs1),
    .i_rs2   (w_ins.body.rs2),
    .i_cur   (w_cur),
    .i_hist  (r_hist),
    .o_stall (w_stall)
  );

  // Instruction memory: write port only, never reset.
  always_ff @(posedge clk) begin
    if (bus.imem_we) r_imem[bus.imem_waddr] <= bus.imem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_HALT: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:           if (!bus.hold && w_ins.halt) w_state_nxt = ST_HALT;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  // Halt wins over hazard; hold freezes everything including the history slot.
  always_comb begin
    w_pc_nxt     = r_pc;
    w_vld_nxt    = r_vld;
    w_iss_nxt    = r_iss;
    w_hist_nxt   = r_hist;
    w_done_nxt   = 1'b0;
    w_icount_nxt = r_icount;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          w_pc_nxt     = bus.start_pc;
          w_icount_nxt = '0;
          w_hist_nxt   = '0;
          w_vld_nxt    = 1'b0;
        end
      end
      ST_RUN: begin
        if (!bus.hold) begin
          w_hist_nxt = w_cur;
          if (w_ins.halt) begin
            w_vld_nxt  = 1'b0;
            w_done_nxt = 1'b1;
          end else if (w_stall) begin
            w_vld_nxt = 1'b0;
            w_iss_nxt = '0;
          end else begin
            w_vld_nxt = 1'b1;
            w_iss_nxt = w_ins.body;
            w_pc_nxt  = r_pc + adr'(1);
            if (r_icount != '1) w_icount_nxt = r_icount + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= '0;
      r_vld    <= 1'b0;
      r_iss    <= '0;
      r_hist   <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_icount <= '0;
    end else begin
      r_pc     <= w_pc_nxt;
      r_vld    <= w_vld_nxt;
      r_iss    <= w_iss_nxt;
      r_hist   <= w_hist_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= (w_state_nxt == ST_RUN);
      r_icount <= w_icount_nxt;
    end
  end

  assign bus.vld    = r_vld;
  assign bus.rs1    = r_iss.rs1;
  assign bus.rs2    = r_iss.rs2;
  assign bus.rd     = r_iss.rd;
  assign bus.f      = r_iss.f;
  assign bus.addr   = r_iss.addr;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.icount = r_icount;

endmodule
